serial_paralelo_rx: RTL and testbench

- Receive end of the phy serial link. Takes the single-bit stream from the transmit serializer and recovers byte alignment by hunting for the idle comma ($BC).
- Declares the link active after SYNC_COUNT consecutive aligned commas.
- Then delivers one 9-bit word per byte time: bit 8 is valid, bits 7:0 are the data byte.
- Feeds the byte-lane demux ahead of the 4-lane paralelo outputs.

---
 rtl/serial_paralelo_rx_if.sv | 21 ++
 rtl/serial_paralelo_rx.sv | 94 +++++++++
 tb/tb_serial_paralelo_rx.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_rx_if.sv
// rtl/serial_paralelo_rx_if.sv - serial link receive side signal bundle
interface serial_paralelo_rx_if;
    logic       data_in;
    logic [8:0] data_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// rtl/serial_paralelo_rx.sv - comma-aligned serial receiver
// Hunts for COMMA bit by bit, confirms SYNC_COUNT aligned commas, then emits one {valid, byte} per byte time.
module serial_paralelo_rx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic                 clk32f,
    input  logic                 reset,
    serial_paralelo_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] SYNC = 3'(SYNC_COUNT);

    state_t     state;
    // Only the seven most recent bits are kept; the eighth comes straight from data_in.
    logic [6:0] sr;
    logic [2:0] bit_cnt;
    logic [2:0] bc_cnt;
    logic [8:0] data_out_r;
    logic       byte_strobe_r;
    logic       active_r;

    logic [7:0] w;
    logic       is_comma;
    logic       boundary;

    assign w        = {sr, bus.data_in};
    assign is_comma = (w == COMMA);
    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state         <= SEARCH;
            sr            <= 7'h00;
            bit_cnt       <= 3'd0;
            bc_cnt        <= 3'd0;
            data_out_r    <= 9'h000;
            byte_strobe_r <= 1'b0;
            active_r      <= 1'b0;
        end else begin
            sr            <= w[6:0];
            byte_strobe_r <= 1'b0;
            case (state)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt <= 3'd0;
                        bc_cnt  <= 3'd1;
                        if (SYNC == 3'd1) begin
                            state    <= ACTIVE;
                            active_r <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    // Mid-byte matches are ignored so shifted data cannot re-anchor the lane.
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt <= bc_cnt + 3'd1;
                            if (bc_cnt + 3'd1 == SYNC) begin
                                state    <= ACTIVE;
                                active_r <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= 3'd0;
                            state  <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        data_out_r    <= {~is_comma, w};
                        byte_strobe_r <= 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign bus.data_out    = data_out_r;
    assign bus.byte_strobe = byte_strobe_r;
    assign bus.active      = active_r;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb/tb_serial_paralelo_rx.sv - scoreboard bench for serial_paralelo_rx (SYNC_COUNT 4 and 1)
module tb_serial_paralelo_rx;

    typedef struct {
        int         edge_n;
        logic [8:0] data;
    } exp_t;

    logic clk32f = 1'b0;
    logic reset  = 1'b0;
    logic din    = 1'b0;

    serial_paralelo_rx_if bus0 ();
    serial_paralelo_rx_if bus1 ();

    assign bus0.data_in = din;
    assign bus1.data_in = din;

    serial_paralelo_rx #(.COMMA(8'hBC), .SYNC_COUNT(4)) u_dut4 (
        .clk32f (clk32f),
        .reset  (reset),
        .bus    (bus0.slave)
    );

    serial_paralelo_rx #(.COMMA(8'hBC), .SYNC_COUNT(1)) u_dut1 (
        .clk32f (clk32f),
        .reset  (reset),
        .bus    (bus1.slave)
    );

    always #5 clk32f = ~clk32f;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t dq [2][$];
    int   aq [2][$];
    logic [8:0] got [2][$];

    // Reference model: bit history plus the edge index of the alignment anchor.
    bit hist[$];
    int ed_stim = 0;
    int m_mode   [2];
    int m_anchor [2];
    int m_cnt    [2];
    int syncn    [2] = '{4, 1};

    int   ed_mon = 0;
    bit   mon_en = 0;
    logic prev_act  [2];
    logic [8:0] last_data [2];
    int   rise_edge [2];

    task automatic chk(input string name, input int actual, input int required);
        n_chk++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    function automatic int window();
        int v = 0;
        for (int k = 0; k < 8; k++) begin
            int idx = hist.size() - 8 + k;
            v = v * 2 + ((idx >= 0) ? int'(hist[idx]) : 0);
        end
        return v;
    endfunction

    task automatic model_step();
        int  w = window();
        for (int i = 0; i < 2; i++) begin
            bit bnd = (m_mode[i] != 0) && (((ed_stim - m_anchor[i]) % 8) == 0);
            case (m_mode[i])
                0: if (w == 188) begin
                    m_anchor[i] = ed_stim;
                    m_cnt[i]    = 1;
                    if (syncn[i] == 1) begin
                        m_mode[i] = 2;
                        aq[i].push_back(ed_stim);
                    end else begin
                        m_mode[i] = 1;
                    end
                end
                1: if (bnd) begin
                    if (w == 188) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == syncn[i]) begin
                            m_mode[i] = 2;
                            aq[i].push_back(ed_stim);
                        end
                    end else begin
                        m_mode[i] = 0;
                        m_cnt[i]  = 0;
                    end
                end
                default: if (bnd) begin
                    exp_t e;
                    e.edge_n = ed_stim;
                    e.data   = 9'(((w != 188) ? 256 : 0) + w);
                    dq[i].push_back(e);
                end
            endcase
        end
    endtask

    task automatic send_bit(input bit b);
        din = b;
        hist.push_back(b);
        ed_stim++;
        model_step();
        @(negedge clk32f);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int k = 7; k >= 0; k--) send_bit(v[k]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_async_active", int'(bus0.active), 0);
        chk("rst_async_strobe", int'(bus0.byte_strobe), 0);
        chk("rst_async_data", int'(bus0.data_out), 0);
        chk("rst_async_active_s1", int'(bus1.active), 0);
        repeat (3) @(negedge clk32f);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_pending_data_at_reset", i), dq[i].size(), 0);
            chk($sformatf("u%0d_pending_active_at_reset", i), aq[i].size(), 0);
            dq[i].delete();
            aq[i].delete();
            got[i].delete();
            m_mode[i]    = 0;
            m_anchor[i]  = 0;
            m_cnt[i]     = 0;
            rise_edge[i] = -1;
        end
        hist.delete();
        ed_stim = 0;
        mon_en  = 1;
        reset   = 1'b0;
    endtask

    task automatic mon(input int i, input logic s, input logic [8:0] d, input logic a);
        if (reset) begin
            chk($sformatf("u%0d_reset_active", i), int'(a), 0);
            chk($sformatf("u%0d_reset_strobe", i), int'(s), 0);
            chk($sformatf("u%0d_reset_data", i), int'(d), 0);
        end else begin
            if (s) begin
                if (dq[i].size() == 0) begin
                    chk($sformatf("u%0d_unexpected_strobe_edge%0d", i, ed_mon), 1, 0);
                end else begin
                    exp_t e = dq[i].pop_front();
                    chk($sformatf("u%0d_strobe_edge", i), ed_mon, e.edge_n);
                    chk($sformatf("u%0d_strobe_data", i), int'(d), int'(e.data));
                    got[i].push_back(d);
                end
            end else if (d !== last_data[i]) begin
                chk($sformatf("u%0d_data_hold_edge%0d", i, ed_mon), int'(d), int'(last_data[i]));
            end
            if (a && !prev_act[i]) begin
                rise_edge[i] = ed_mon;
                if (aq[i].size() == 0)
                    chk($sformatf("u%0d_unexpected_active_edge%0d", i, ed_mon), 1, 0);
                else
                    chk($sformatf("u%0d_active_rise_edge", i), ed_mon, aq[i].pop_front());
            end else if (!a && prev_act[i]) begin
                chk($sformatf("u%0d_active_dropped_edge%0d", i, ed_mon), 0, 1);
            end
        end
        prev_act[i]  = a;
        last_data[i] = d;
    endtask

    always @(posedge clk32f) begin
        #1;
        if (mon_en) begin
            if (reset) ed_mon = 0;
            else       ed_mon++;
            mon(0, bus0.byte_strobe, bus0.data_out, bus0.active);
            mon(1, bus1.byte_strobe, bus1.data_out, bus1.active);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp4 [4];
        exp4[0] = 9'h1FF; exp4[1] = 9'h1F5; exp4[2] = 9'h0BC; exp4[3] = 9'h155;

        repeat (2) @(negedge clk32f);
        do_reset();

        // Reset to sync: two random bits then four commas.
        send_bit(1'($urandom_range(0, 1)));
        send_bit(1'($urandom_range(0, 1)));
        repeat (3) send_byte(8'hBC);
        chk("sync_not_early", int'(bus0.active), 0);
        send_byte(8'hBC);
        chk("sync_rise_edge", rise_edge[0], 34);

        // Data after sync.
        got[0].delete();
        send_byte(8'hFF); send_byte(8'hF5); send_byte(8'hBC); send_byte(8'h55);
        chk("data_count", got[0].size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got[0].size()) chk($sformatf("data_word%0d", k), int'(got[0][k]), int'(exp4[k]));
        repeat (12) send_byte(8'($urandom));

        // Reset while active, mid-byte.
        repeat (3) send_bit(1'($urandom_range(0, 1)));
        do_reset();
        repeat (3) send_byte(8'hBC);
        chk("resync_not_early", int'(bus0.active), 0);
        send_byte(8'hBC);
        chk("resync_rise_edge", rise_edge[0], 32);
        repeat (6) send_byte(8'($urandom));

        // Broken sync.
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h3C);
        repeat (4) send_byte(8'hBC);
        chk("broken_rise_edge", rise_edge[0], 56);
        repeat (4) send_byte(8'($urandom));

        // False comma spanning a byte boundary.
        do_reset();
        send_byte(8'hBC); send_byte(8'h0B); send_byte(8'hC0);
        repeat (4) send_byte(8'h00);
        chk("false_comma_inactive", int'(bus0.active), 0);

        // SYNC_COUNT=1 build.
        do_reset();
        send_byte(8'hBC);
        chk("s1_rise_edge", rise_edge[1], 8);
        send_byte(8'hAA);
        chk("s1_first_count", got[1].size(), 1);
        if (got[1].size() > 0) chk("s1_first_word", int'(got[1][0]), 9'h1AA);

        // Random run with random bit offset.
        do_reset();
        repeat ($urandom_range(0, 7)) send_bit(1'b0);
        repeat (4) send_byte(8'hBC);
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'hBC);
            else                           send_byte(8'($urandom));
        end
        repeat (2) @(negedge clk32f);

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_final_data_queue", i), dq[i].size(), 0);
            chk($sformatf("u%0d_final_active_queue", i), aq[i].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
